vram_pixel_writer: RTL and testbench
====================================

VRAM_PIXEL_WRITER -- requirements
Module: vram_pixel_writer

Interface
REQ-001 Parameter H_RES, default 512, shall set the framebuffer width in pixels.
REQ-002 Parameter V_RES, default 480, shall set the framebuffer height; H_RES*V_RES shall not exceed 2^18.
REQ-003 Parameter FIFO_DEPTH, default 4, shall set the request buffer depth; it shall be a power of two and at least 2.
REQ-004 Parameter CLEAR_COLOR, default 8'h00, shall set the fill value used by the clear engine.
REQ-005 The ports shall be, one per line (name, direction, width, meaning):
  clk  in  1  single clock; all state on its rising edge
  reset  in  1  asynchronous, active-high reset
  req_valid  in  1  pixel write request valid
  req_ready  out  1  request accepted when req_valid && req_ready
  req_x  in  10  pixel column
  req_y  in  9  pixel row
  req_color  in  8  pixel value (RRRGGGBB)
  clear_start  in  1  single-cycle pulse that requests a framebuffer fill
  clear_busy  out  1  high while the fill or pre-fill drain is in progress
  vram_we  out  1  VRAM write strobe, one write per cycle
  vram_addr  out  18  VRAM write address
  vram_wdata  out  8  VRAM write data
  drop_count  out  16  count of out-of-range requests, saturating

Function
REQ-006 The FSM shall have three states: IDLE, DRAIN and CLEAR.
REQ-007 req_ready shall be 1 only in IDLE with the FIFO not full; it shall be combinational from the state and FIFO level.
REQ-008 An accepted request shall push {addr = req_y*H_RES + req_x (18 bits), color} into the FIFO in the same cycle.
REQ-009 When the FIFO is non-empty, each cycle shall pop one entry and register it onto vram_addr/vram_wdata with vram_we=1 in the next cycle.
REQ-010 Latency: a request accepted in cycle N into an empty FIFO shall produce vram_we=1 in cycle N+2; sustained throughput shall be one write per cycle.
REQ-011 A simultaneous push and pop shall leave the FIFO level unchanged; a push into a full FIFO cannot occur because req_ready=0.
REQ-012 vram_we shall be 0 in any cycle with nothing popped and no clear write; vram_addr/vram_wdata shall hold their last values.
REQ-013 A pulse on clear_start in IDLE shall move the FSM to DRAIN; a request accepted in that same cycle shall still be written before the fill starts.
REQ-014 DRAIN shall move to CLEAR on the first cycle the FIFO is empty and no pop is pending.
REQ-015 CLEAR shall write CLEAR_COLOR to addresses 0 to H_RES*V_RES-1 in ascending order, one per cycle with vram_we=1, then return to IDLE.
REQ-016 clear_busy shall be 1 in DRAIN and CLEAR; clear_start outside IDLE shall be ignored.

Reset
REQ-017 Asynchronous assertion of reset shall immediately force: FSM=IDLE; FIFO empty; clear counter=0; vram_we=0; vram_addr=0; vram_wdata=0; drop_count=0; clear_busy=0.
REQ-018 Reset mid-fill or with a non-empty FIFO shall discard all pending work; no write shall issue in the first cycle after release.

Configuration
REQ-019 Macro PIXEL_BOUNDS_CHECK_EN, when defined, shall accept requests with req_x>=H_RES or req_y>=V_RES but not push them, and shall increment drop_count, saturating at 16'hFFFF.
REQ-020 Without PIXEL_BOUNDS_CHECK_EN, every accepted request shall be pushed with its computed address truncated to 18 bits, and drop_count shall be tied to 0.

Verification
REQ-021 Single write: x=3, y=2, color=8'hE0 into an idle, empty block -> exactly one vram_we pulse 2 cycles after acceptance, with addr=1027 and data=E0.
REQ-022 Burst: 6 back-to-back requests while the sink is always writing -> req_ready stays 1, writes appear in order on 6 consecutive cycles, FIFO level never exceeds 2.
REQ-023 Clear with pending work: 3 requests accepted, then clear_start -> those 3 writes first, then addresses 0..245759 with data 00; clear_busy high throughout; req_ready=0 until return to IDLE.
REQ-024 Reset at clear address 1000 -> vram_we=0 immediately; after release, FSM is IDLE and the next request writes normally.
REQ-025 With PIXEL_BOUNDS_CHECK_EN: x=600, y=10 -> accepted, no vram_we, drop_count=1; without the macro -> write to (10*512+600) mod 2^18.

Source files
------------

// File: rtl/vram_pixel_writer.sv
// vram_pixel_writer: buffers pixel write requests and streams them to VRAM one
// write per cycle; a clear engine fills the whole framebuffer with CLEAR_COLOR
// after draining any requests already accepted.
//
// Optional feature macro: PIXEL_BOUNDS_CHECK_EN -- out-of-range requests are
// accepted but discarded and counted in drop_count (saturating). Without it,
// every accepted request is written at its 18-bit truncated address.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req_valid/req_ready   pixel request handshake (req_ready combinational)
//   req_x, req_y          pixel column (10b) / row (9b)
//   req_color             pixel value RRRGGGBB
//   clear_start           one-cycle pulse requesting a framebuffer fill
//   clear_busy            high while draining before / during the fill
//   vram_we/addr/wdata    registered VRAM write port
//   drop_count            out-of-range request count (0 without bounds check)

package vram_pixel_writer_pkg;
   localparam int unsigned ADDR_W  = 18;
   localparam int unsigned COLOR_W = 8;

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [COLOR_W-1:0] color;
   } pix_req_t;
endpackage

module vram_pixel_writer
   import vram_pixel_writer_pkg::*;
#(
   parameter int unsigned H_RES       = 512,
   parameter int unsigned V_RES       = 480,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter logic [7:0]  CLEAR_COLOR = 8'h00
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [9:0]   req_x,
   input  logic [8:0]   req_y,
   input  logic [7:0]   req_color,
   input  logic         clear_start,
   output logic         clear_busy,
   output logic         vram_we,
   output logic [17:0]  vram_addr,
   output logic [7:0]   vram_wdata,
   output logic [15:0]  drop_count
);

   localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W     = PTR_W + 1;
   localparam int unsigned PIX_TOTAL = H_RES * V_RES;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_TOTAL - 1);

   typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   clr_q, clr_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [COLOR_W-1:0]  wdata_q, wdata_d;
   logic                busy_q, busy_d;

   pix_req_t            mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wptr_q, rptr_q;
   logic [LVL_W-1:0]    level_q;
   logic                fifo_empty, fifo_full;
   logic                accept, push, pop;
   pix_req_t            push_data;
   pix_req_t            pop_data;

   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
   assign req_ready  = (state_q == IDLE) && !fifo_full;
   assign accept     = req_valid && req_ready;
   // FIFO is always empty in CLEAR; the guard keeps pops out of the fill stream.
   assign pop        = !fifo_empty && (state_q != CLEAR);
   assign pop_data   = mem_q[rptr_q];

   // Address math done modulo 2^18, which is the required truncation.
   assign push_data.addr  = ADDR_W'(req_y) * ADDR_W'(H_RES) + ADDR_W'(req_x);
   assign push_data.color = req_color;

`ifdef PIXEL_BOUNDS_CHECK_EN
   logic        in_range;
   logic [15:0] drop_q;

   assign in_range   = (32'(req_x) < H_RES) && (32'(req_y) < V_RES);
   assign push       = accept && in_range;
   assign drop_count = drop_q;

   // Saturating count of accepted-but-discarded requests.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_q <= '0;
      end else if (accept && !in_range && (drop_q != 16'hFFFF)) begin
         drop_q <= drop_q + 16'd1;
      end
   end
`else
   assign push       = accept;
   assign drop_count = '0;
`endif

   // FIFO pointers and level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + PTR_W'(1);
         if (pop)  rptr_q <= rptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // FIFO storage; contents are don't-care while the level says empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= push_data;
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         clr_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state and write-port selection.
   always_comb begin
      state_d = state_q;
      clr_d   = clr_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      busy_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (clear_start) state_d = DRAIN;
         end
         DRAIN: begin
            // Empty FIFO means no pop this cycle; the last drained write is
            // already in the output register.
            if (fifo_empty) state_d = CLEAR;
         end
         CLEAR: begin
            we_d    = 1'b1;
            addr_d  = clr_q;
            wdata_d = CLEAR_COLOR;
            if (clr_q == LAST_ADDR) begin
               clr_d   = '0;
               state_d = IDLE;
            end else begin
               clr_d = clr_q + ADDR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (pop) begin
         we_d    = 1'b1;
         addr_d  = pop_data.addr;
         wdata_d = pop_data.color;
      end

      // Stays high through the cycle that shows the final fill write.
      busy_d = (state_d != IDLE) || (state_q == CLEAR);
   end

   assign vram_we    = we_q;
   assign vram_addr  = addr_q;
   assign vram_wdata = wdata_q;
   assign clear_busy = busy_q;

endmodule

// File: tb/tb_vram_pixel_writer.sv
// Testbench for vram_pixel_writer: table of single writes, burst, randomized
// traffic against a delay-queue reference model, clear sequencing and resets.
// Framebuffer is 512x8 so a full fill stays short.

module tb_vram_pixel_writer;

   localparam int unsigned TB_H = 512;
   localparam int unsigned TB_V = 8;
   localparam int unsigned NPIX = TB_H * TB_V;
`ifdef PIXEL_BOUNDS_CHECK_EN
   localparam bit BOUNDS = 1'b1;
`else
   localparam bit BOUNDS = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [9:0]   req_x = '0;
   logic [8:0]   req_y = '0;
   logic [7:0]   req_color = '0;
   logic         clear_start = 1'b0;
   logic         clear_busy;
   logic         vram_we;
   logic [17:0]  vram_addr;
   logic [7:0]   vram_wdata;
   logic [15:0]  drop_count;

   vram_pixel_writer #(
      .H_RES       (TB_H),
      .V_RES       (TB_V),
      .FIFO_DEPTH  (4),
      .CLEAR_COLOR (8'h00)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_x       (req_x),
      .req_y       (req_y),
      .req_color   (req_color),
      .clear_start (clear_start),
      .clear_busy  (clear_busy),
      .vram_we     (vram_we),
      .vram_addr   (vram_addr),
      .vram_wdata  (vram_wdata),
      .drop_count  (drop_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [17:0] addr;
      logic [7:0]  color;
      int          due;
   } exp_t;

   typedef struct {
      logic [9:0]  x;
      logic [8:0]  y;
      logic [7:0]  color;
      logic        exp_we;
      logic [17:0] exp_addr;
   } vec_t;

   exp_t exp_q[$];
   vec_t tbl[4];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   drop_exp = 0;
   bit   sb_on = 1'b0;
   bit   found;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // Reference: linear address modulo 2^18.
   function automatic logic [17:0] model_addr(input int x, input int y);
      int a;
      a = y * int'(TB_H) + x;
      return 18'(a % 262144);
   endfunction

   function automatic bit model_keep(input int x, input int y);
      if (BOUNDS) return (x < int'(TB_H)) && (y < int'(TB_V));
      return 1'b1;
   endfunction

   // One clock: scoreboard check and handshake capture at negedge, then advance.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (sb_on) begin
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("sb_write", 32'({vram_we, vram_addr, vram_wdata}),
                32'({1'b1, exp_q[0].addr, exp_q[0].color}));
            void'(exp_q.pop_front());
         end else begin
            chk("sb_idle", 32'(vram_we), 32'd0);
         end
      end
      if (req_valid && req_ready) begin
         if (model_keep(int'(req_x), int'(req_y))) begin
            if (sb_on) begin
               e.addr  = model_addr(int'(req_x), int'(req_y));
               e.color = req_color;
               e.due   = cyc + 2;
               exp_q.push_back(e);
            end
         end else if (drop_exp < 65535) begin
            drop_exp++;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   initial begin
      tbl[0] = '{x: 10'd3,   y: 9'd2,  color: 8'hE0, exp_we: 1'b1,    exp_addr: 18'd1027};
      tbl[1] = '{x: 10'd0,   y: 9'd0,  color: 8'h55, exp_we: 1'b1,    exp_addr: 18'd0};
      tbl[2] = '{x: 10'd511, y: 9'd7,  color: 8'hFF, exp_we: 1'b1,    exp_addr: 18'd4095};
      tbl[3] = '{x: 10'd600, y: 9'd10, color: 8'h1C, exp_we: !BOUNDS, exp_addr: 18'd5720};

      // Reset state, asserted asynchronously before any clock edge.
      #1 reset = 1'b1;
      #1;
      chk("rst_outputs", 32'({vram_we, vram_addr, vram_wdata, clear_busy, drop_count}), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
      @(posedge clk); cyc++;
      @(posedge clk); cyc++;
      #1 reset = 1'b0;

      // Single writes: exact two-cycle latency and a lone pulse.
      sb_on = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1;
         req_x = tbl[i].x; req_y = tbl[i].y; req_color = tbl[i].color;
         chk("tbl_ready", 32'(req_ready), 32'd1);
         tick();
         req_valid = 1'b0;
         chk("tbl_lat1", 32'(vram_we), 32'd0);
         tick();
         chk("tbl_we", 32'(vram_we), 32'(tbl[i].exp_we));
         if (tbl[i].exp_we) begin
            chk("tbl_addr", 32'(vram_addr), 32'(tbl[i].exp_addr));
            chk("tbl_data", 32'(vram_wdata), 32'(tbl[i].color));
         end
         tick();
         chk("tbl_after", 32'(vram_we), 32'd0);
      end
      chk("tbl_drop", 32'(drop_count), 32'(drop_exp));

      // Burst of six back-to-back requests.
      sb_on = 1'b1;
      for (int i = 0; i < 6; i++) begin
         req_valid = 1'b1;
         req_x = 10'(i * 37); req_y = 9'(i % 8); req_color = 8'(8'h30 + i);
         chk("burst_ready", 32'(req_ready), 32'd1);
         tick();
      end
      req_valid = 1'b0;
      repeat (4) tick();
      chk("burst_drained", 32'(exp_q.size()), 32'd0);

      // Randomized traffic; the sink drains every cycle so ready must stay high.
      for (int i = 0; i < 400; i++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) begin
            req_x = 10'($urandom_range(0, 1023));
            req_y = 9'($urandom_range(0, 511));
         end else begin
            req_x = 10'($urandom_range(0, 511));
            req_y = 9'($urandom_range(0, 7));
         end
         req_color = 8'($urandom);
         chk("rnd_ready", 32'(req_ready), 32'd1);
         tick();
      end
      req_valid = 1'b0;
      repeat (4) tick();
      chk("rnd_drained", 32'(exp_q.size()), 32'd0);
      chk("rnd_drop", 32'(drop_count), 32'(drop_exp));

      // Clear with three pending writes; clear_start shares a cycle with the third.
      for (int k = 0; k < 3; k++) begin
         req_valid = 1'b1;
         req_x = 10'(10 + k); req_y = 9'(k); req_color = 8'(8'h11 * (k + 1));
         clear_start = (k == 2);
         chk("clr_pre_ready", 32'(req_ready), 32'd1);
         tick();
      end
      clear_start = 1'b0;
      req_color = 8'hAA;
      for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
         chk("drain_busy", 32'({clear_busy, req_ready}), 32'b10);
         tick();
      end
      chk("drain_done", 32'(exp_q.size()), 32'd0);
      sb_on = 1'b0;
      for (int k = 0; k < 16 && !vram_we; k++) begin
         chk("clr_gap", 32'({clear_busy, req_ready}), 32'b10);
         tick();
      end
      for (int i = 0; i < int'(NPIX); i++) begin
         chk("clr_write", 32'({vram_we, vram_addr, vram_wdata, clear_busy}),
             32'({1'b1, 18'(i), 8'h00, 1'b1}));
         if (i < int'(NPIX) - 1) chk("clr_ready", 32'(req_ready), 32'd0);
         req_valid   = (i < int'(NPIX) - 1);
         clear_start = (i == 2000);
         tick();
      end
      req_valid = 1'b0;
      clear_start = 1'b0;
      chk("clr_done", 32'({vram_we, clear_busy, req_ready}), 32'b001);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("clr_no_restart", 32'({vram_we, clear_busy}), 32'b00);
      end

      // Reset with an entry still in the FIFO.
      req_valid = 1'b1; req_x = 10'd5; req_y = 9'd1; req_color = 8'h77;
      tick();
      req_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("rstq_async", 32'({vram_we, clear_busy}), 32'd0);
      @(posedge clk); cyc++;
      #1 reset = 1'b0;
      exp_q.delete();
      drop_exp = 0;
      sb_on = 1'b1;
      repeat (4) tick();

      // Reset while the fill is at address 1000.
      sb_on = 1'b0;
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 1100 && !found; k++) begin
         if (vram_we && vram_addr == 18'd1000) found = 1'b1;
         else tick();
      end
      chk("clr_reach_1000", 32'(found), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rstc_async", 32'({vram_we, vram_addr, vram_wdata, clear_busy}), 32'd0);
      @(posedge clk); cyc++;
      #1 reset = 1'b0;
      chk("rstc_idle", 32'({req_ready, clear_busy}), 32'b10);
      exp_q.delete();
      drop_exp = 0;
      sb_on = 1'b1;
      repeat (3) tick();
      req_valid = 1'b1; req_x = 10'd3; req_y = 9'd2; req_color = 8'hE0;
      tick();
      req_valid = 1'b0;
      repeat (4) tick();
      chk("post_rst_drained", 32'(exp_q.size()), 32'd0);
      chk("final_drop", 32'(drop_count), 32'(drop_exp));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
